jumper_cfg_sequencer: RTL
=========================

// Module: jumper_cfg_sequencer
// PURPOSE
//  Sits between the jumper-sampling logic and the memory controller config port.
//  Qualifies raw mode samples (N identical consecutive samples) and waits for the end of CPU reset.
//  Then commits exactly one decoded memory mode downstream via a req/ack handshake and holds it locked until the next CPU reset.
//  Falls back to mode NONE if the samples are not stable within a timeout after reset end.
// PARAMETERS
//  CONFIRM      4     identical consecutive valid samples required for "stable" (>=1)
//  CNT_W        3     width of confirm counter; must hold CONFIRM
//  TIMEOUT      4096  clocks allowed after CPU-reset end to reach stable before fallback
//  TO_W         13    width of timeout counter; must hold TIMEOUT
// PORTS
//  clock        in   1  system clock
//  reset        in   1  synchronous, active-high block reset
//  cpu_nreset   in   1  async Amiga reset, active-low; 2-flop synchronised internally
//  samp_valid   in   1  one-clock strobe: samp_mode holds a fresh jumper sample
//  samp_mode    in   4  {slow4mb,slow,4mb,8mb} one-hot or all-zero (= none)
//  cfg_req      out  1  commit request to memory controller
//  cfg_ack      in   1  memory controller accepted cfg_mode
//  cfg_mode     out  3  0=NONE 1=4MB 2=8MB 3=SLOW 4=SLOW4MB; 5..7 never driven
//  cfg_locked   out  1  committed config valid
//  cfg_fallback out  1  last commit was a timeout fallback to NONE
//  samp_err     out  1  one-clock pulse: sample had >1 bit set
// BEHAVIOUR
//  Reset: state=ACQUIRE, cand=NONE, cnt=0, stable=0, timeout=0.
//   All outputs 0. Sync flops preset to 0, i.e. CPU in reset.
//  Decode: all-zero->NONE. Exactly one bit set->its code. >1 bit set->invalid:
//   samp_err=1 next clock, cnt<=0, cand unchanged.
//  Stability (ACQUIRE/STABLE, on samp_valid & valid decode):
//   code==cand -> cnt<=cnt+1, saturating at CONFIRM. Else -> cand<=code, cnt<=1.
//   stable = (cnt==CONFIRM), registered. CONFIRM=1: first valid sample makes stable.
//  rst_end = sync'd cpu_nreset 0->1 edge, one clock. rst_on = sync'd cpu_nreset==0.
//  FSM:
//   ACQUIRE: keep qualifying. rst_end & stable -> COMMIT(cand).
//            rst_end & !stable -> WAIT, timeout<=0.
//   WAIT: keep qualifying; timeout++ every clock.
//         stable -> COMMIT(cand), fallback=0.
//         timeout==TIMEOUT-1 & !stable -> COMMIT(NONE), fallback=1.
//         rst_on -> ACQUIRE; cnt, cand kept.
//   COMMIT: cfg_req=1 from entry clock. cfg_mode set at entry, constant while req=1.
//           cfg_ack high on a clock -> cfg_req=0 on the next clock.
//           Then ->LOCKED (cfg_locked=1, same clock as req drop); cfg_fallback updated then.
//           Samples ignored. rst_on never aborts a handshake: after ack go to ACQUIRE, not LOCKED.
//   LOCKED: samples ignored; cfg_mode, cfg_locked held.
//           rst_on -> ACQUIRE: cfg_locked=0, cnt=0, stable=0; cfg_mode keeps last value.
//  cfg_ack while cfg_req=0: ignored.
//  Handshake latency: req->ack min 0 clocks, i.e. ack in the req entry clock is legal.
//  Block reset mid-handshake: req drops next clock, full reset state.
//  rst_end to cfg_req: rst_end sample clock +1 when already stable.
//  Timeout counter saturates; it never wraps.
// TESTING
//  T1: 4x samp_valid 8MB, cpu_nreset 0->1 -> cfg_req, cfg_mode=2; ack after 3 clks
//      -> req low next clk, cfg_locked=1, fallback=0.
//  T2: samples 4MB,4MB,8MB,8MB,8MB,8MB -> commit only after 4th 8MB; cfg_mode=2, never 1.
//  T3: samp_mode=4'b0011 -> samp_err pulse 1 clk, cnt cleared;
//      stable needs 4 further identical samples.
//  T4: no samples after reset end -> at TIMEOUT clocks cfg_req, cfg_mode=0, cfg_fallback=1.
//  T5: cpu_nreset low during COMMIT, ack 5 clks later -> req held until ack;
//      then ACQUIRE, cfg_locked=0. Re-commit on next reset end.
//  T6: block reset during COMMIT -> cfg_req=0 next clk; all outputs 0.
//      Ack with req low is ignored.

Source files
------------

// File: rtl/jumper_cfg_sequencer.sv
// Qualifies jumper mode samples, waits for the end of CPU reset, then commits one
// decoded memory mode to the memory controller via req/ack and holds it locked.
module jumper_cfg_sequencer #(
  parameter int unsigned CONFIRM = 4,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TO_W    = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_nreset,
  input  logic       samp_valid,
  input  logic [3:0] samp_mode,
  output logic       cfg_req,
  input  logic       cfg_ack,
  output logic [2:0] cfg_mode,
  output logic       cfg_locked,
  output logic       cfg_fallback,
  output logic       samp_err
);

  localparam int unsigned MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_NONE    = 3'd0;
  localparam logic [MODE_W-1:0] MODE_4MB     = 3'd1;
  localparam logic [MODE_W-1:0] MODE_8MB     = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SLOW    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_SLOW4MB = 3'd4;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_WAIT    = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q;
  logic [MODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stable_q, stable_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic              pend_fb_q, pend_fb_d;
  logic              abort_q, abort_d;
  logic              req_d, locked_d, fb_d, err_d;
  logic [MODE_W-1:0] mode_d;
  logic [MODE_W-1:0] code;
  logic              code_ok;
  logic              qualify;
  logic              rst_on, rst_end;

  // sync_q[0..1] is the 2-flop synchroniser, sync_q[2] delays it for edge detection
  assign rst_on  = ~sync_q[1];
  assign rst_end = sync_q[1] & ~sync_q[2];
  assign qualify = (state_q == ST_ACQUIRE) || (state_q == ST_WAIT);

  // Jumper decode: bits are {slow4mb, slow, 4mb, 8mb}; more than one bit set is invalid
  always_comb begin
    code    = MODE_NONE;
    code_ok = 1'b1;
    case (samp_mode)
      4'b0000: code = MODE_NONE;
      4'b0001: code = MODE_8MB;
      4'b0010: code = MODE_4MB;
      4'b0100: code = MODE_SLOW;
      4'b1000: code = MODE_SLOW4MB;
      default: code_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    pend_fb_d = pend_fb_q;
    abort_d   = abort_q;
    req_d     = cfg_req;
    mode_d    = cfg_mode;
    locked_d  = cfg_locked;
    fb_d      = cfg_fallback;
    err_d     = samp_valid & ~code_ok;

    if (qualify && samp_valid) begin
      if (!code_ok) begin
        cnt_d = '0;
      end else if (code == cand_q) begin
        if (cnt_q != CNT_W'(CONFIRM)) cnt_d = CNT_W'(cnt_q + 1'b1);
      end else begin
        cand_d = code;
        cnt_d  = CNT_W'(1);
      end
    end

    case (state_q)
      ST_ACQUIRE: begin
        if (rst_end) begin
          if (stable_q) begin
            state_d   = ST_COMMIT;
            req_d     = 1'b1;
            mode_d    = cand_q;
            pend_fb_d = 1'b0;
            abort_d   = 1'b0;
          end else begin
            state_d = ST_WAIT;
            tmo_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (tmo_q != TO_W'(TIMEOUT)) tmo_d = TO_W'(tmo_q + 1'b1);
        if (stable_q) begin
          state_d   = ST_COMMIT;
          req_d     = 1'b1;
          mode_d    = cand_q;
          pend_fb_d = 1'b0;
          abort_d   = 1'b0;
        end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = ST_COMMIT;
          req_d     = 1'b1;
          mode_d    = MODE_NONE;
          pend_fb_d = 1'b1;
          abort_d   = 1'b0;
        end else if (rst_on) begin
          state_d = ST_ACQUIRE;
        end
      end
      ST_COMMIT: begin
        // A CPU reset seen during the handshake is remembered and honoured once acked
        abort_d = abort_q | rst_on;
        if (cfg_ack) begin
          req_d   = 1'b0;
          fb_d    = pend_fb_q;
          abort_d = 1'b0;
          if (abort_q || rst_on) begin
            state_d  = ST_ACQUIRE;
            locked_d = 1'b0;
            cnt_d    = '0;
          end else begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (rst_on) begin
          state_d  = ST_ACQUIRE;
          locked_d = 1'b0;
          cnt_d    = '0;
        end
      end
      default: state_d = ST_ACQUIRE;
    endcase

    stable_d = (cnt_d == CNT_W'(CONFIRM));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_ACQUIRE;
      sync_q       <= '0;
      cand_q       <= MODE_NONE;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      tmo_q        <= '0;
      pend_fb_q    <= 1'b0;
      abort_q      <= 1'b0;
      cfg_req      <= 1'b0;
      cfg_mode     <= MODE_NONE;
      cfg_locked   <= 1'b0;
      cfg_fallback <= 1'b0;
      samp_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[1:0], cpu_nreset};
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      tmo_q        <= tmo_d;
      pend_fb_q    <= pend_fb_d;
      abort_q      <= abort_d;
      cfg_req      <= req_d;
      cfg_mode     <= mode_d;
      cfg_locked   <= locked_d;
      cfg_fallback <= fb_d;
      samp_err     <= err_d;
    end
  end

endmodule
